// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a small circular FIFO behind a valid/ready
// input, an internal baud divider and a frame FSM
// (start, data LSB first, optional parity, one or two stop bits).
// Every output comes straight from a register or from a decode of a register.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 104,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  // Frame engine state
  logic [2:0]           state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  logic                 push;
  logic                 pop;
  logic                 load;
  logic                 div_last;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  // Full is decoded from the registered count only, so a pop in the same
  // cycle never opens the port combinationally.
  assign in_ready   = (count_q != CNT_W'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign div_last   = (div_q == DIV_W'(CLK_DIV - 1));

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

  // Parity of the word at the FIFO head, computed while it is being loaded
  always_comb begin
    head_par = ^head;
    if (PARITY == 1) begin
      head_par = ~head_par;
    end
  end

  // Frame FSM: bit timing, shifting and the pop decision
  always_comb begin
    state_d = state_q;
    div_d   = div_last ? '0 : div_q + DIV_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        div_d = '0;
        tx_d  = 1'b1;
        if (!fifo_empty) begin
          load = 1'b1;
        end
      end

      S_START: begin
        if (div_last) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (div_last) begin
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = S_PAR;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end

      S_PAR: begin
        if (div_last) begin
          tx_d    = 1'b1;
          bit_d   = '0;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (div_last) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit when more data waits.
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              tx_d    = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        div_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      shift_d = head;
      par_d   = head_par;
      tx_d    = 1'b0;
      div_d   = '0;
      bit_d   = '0;
      state_d = S_START;
    end
  end

  assign pop = load;

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  // Control registers: cleared by reset, abandoning any frame in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data registers: contents only matter once qualified by the control state
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances with different frame settings,
// a scoreboard of expected line patterns and a line monitor.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       vld;
  logic [7:0] din;
  int         sel;
  int         cyc = 0;
  bit         mon_en;
  bit         mon_busy;

  int vectors = 0;
  int miscompares = 0;

  logic       rdy0, tx0, busy0;
  logic       rdy1, tx1, busy1;
  logic       rdy2, tx2, busy2;
  logic       rdy3, tx3, busy3;
  logic [2:0] cnt0, cnt1, cnt2, cnt3;

  logic       tx_m, rdy_m, busy_m;
  logic [2:0] cnt_m;
  int         cdiv_m;

  typedef struct {
    logic [15:0] bits;
    int          nb;
    int          acc;
    bit          gap0;
  } frame_t;

  frame_t sb[$];

  uart_tx_fifo #(.CLK_DIV(4)) u_def (
    .clk(clk), .rst_n(rst_n), .in_valid(vld && sel == 0), .in_data(din),
    .in_ready(rdy0), .tx(tx0), .busy(busy0), .fifo_count(cnt0));

  uart_tx_fifo #(.CLK_DIV(4), .PARITY(2)) u_even (
    .clk(clk), .rst_n(rst_n), .in_valid(vld && sel == 1), .in_data(din),
    .in_ready(rdy1), .tx(tx1), .busy(busy1), .fifo_count(cnt1));

  uart_tx_fifo #(.CLK_DIV(4), .PARITY(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .in_valid(vld && sel == 2), .in_data(din),
    .in_ready(rdy2), .tx(tx2), .busy(busy2), .fifo_count(cnt2));

  uart_tx_fifo #(.CLK_DIV(3), .DATA_BITS(5), .STOP_BITS(2)) u_fmt (
    .clk(clk), .rst_n(rst_n), .in_valid(vld && sel == 3), .in_data(din[4:0]),
    .in_ready(rdy3), .tx(tx3), .busy(busy3), .fifo_count(cnt3));

  assign tx_m   = (sel == 0) ? tx0   : (sel == 1) ? tx1   : (sel == 2) ? tx2   : tx3;
  assign rdy_m  = (sel == 0) ? rdy0  : (sel == 1) ? rdy1  : (sel == 2) ? rdy2  : rdy3;
  assign busy_m = (sel == 0) ? busy0 : (sel == 1) ? busy1 : (sel == 2) ? busy2 : busy3;
  assign cnt_m  = (sel == 0) ? cnt0  : (sel == 1) ? cnt1  : (sel == 2) ? cnt2  : cnt3;
  assign cdiv_m = (sel == 3) ? 3 : 4;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: decodes the selected line and compares each frame to the queue
  initial begin
    bit          in_fr;
    bit          junk;
    bit          bad;
    frame_t      cur;
    int          k;
    int          b;
    int          last_end;
    logic [15:0] act;
    in_fr = 0; junk = 0; bad = 0; k = 0; b = 0; last_end = -100; act = '0;
    mon_busy = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_fr = 0;
        junk  = 0;
      end else if (junk) begin
        if (tx_m == 1'b1) junk = 0;
      end else begin
        if (!in_fr && tx_m == 1'b0) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame: start bit at cycle %0d, expected idle line", cyc);
            junk = 1;
          end else begin
            cur   = sb.pop_front();
            in_fr = 1;
            k     = 0;
            bad   = 0;
            act   = '0;
            if (cur.acc >= 0) check("start_latency", cyc - cur.acc, 1);
            if (cur.gap0) check("back_to_back_gap", cyc - last_end, 1);
          end
        end
        if (in_fr) begin
          b = k / cdiv_m;
          if (tx_m !== cur.bits[b]) bad = 1;
          if ((k % cdiv_m) == (cdiv_m / 2)) act[b] = tx_m;
          k++;
          if (k == cur.nb * cdiv_m) begin
            vectors++;
            if (bad) begin
              miscompares++;
              $display("FAIL frame sel%0d: line %b, expected %b (%0d bits x %0d clks)",
                       sel, act, cur.bits, cur.nb, cdiv_m);
            end
            in_fr    = 0;
            last_end = cyc;
          end
        end
      end
      mon_busy = in_fr;
    end
  end

  task automatic push_word(input logic [7:0] d, input logic [15:0] bits, input int nb);
    int guard;
    guard = 0;
    @(negedge clk);
    din = d;
    vld = 1'b1;
    while (!rdy_m && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!rdy_m) begin
      vld = 1'b0;
      check("push_ready_timeout", 0, 1);
    end else begin
      @(posedge clk);
      @(negedge clk);
      vld = 1'b0;
      sb.push_back('{bits, nb, cyc, 1'b0});
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: %0d frames still pending after %0d clks", name, sb.size(), budget);
      sb.delete();
    end
    @(negedge clk);
    @(negedge clk);
    check({name, "_busy_idle"}, int'(busy_m), 0);
    check({name, "_count_idle"}, int'(cnt_m), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] fw [6];
    int i, guard, maxc;
    bit saw_full, r;

    fw[0] = 16'b000000_1_01000001_0;
    fw[1] = 16'b000000_1_01000010_0;
    fw[2] = 16'b000000_1_01000011_0;
    fw[3] = 16'b000000_1_01000100_0;
    fw[4] = 16'b000000_1_01000101_0;
    fw[5] = 16'b000000_1_01000110_0;

    rst_n = 1'b0; vld = 1'b1; din = 8'hFF; sel = 0; mon_en = 0;

    // Reset held 3 clocks with a word offered
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset_tx", int'(tx0), 1);
      check("reset_ready", int'(rdy0), 1);
      check("reset_busy", int'(busy0), 0);
      check("reset_count", int'(cnt0), 0);
    end
    vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("no_accept_in_reset", int'(cnt0), 0);
    check("idle_line_fmt", int'(tx3), 1);
    mon_en = 1;

    // Single word, 8N1
    sel = 0;
    push_word(8'h48, 16'b000000_1_01001000_0, 10);
    check("busy_after_accept", int'(busy_m), 1);
    check("count_after_accept", int'(cnt_m), 1);
    wait_done("single", 200);
    check("single_line_idle", int'(tx_m), 1);

    // Even then odd parity
    sel = 1;
    push_word(8'h48, 16'b00000_1_0_01001000_0, 11);
    wait_done("even", 200);
    sel = 2;
    push_word(8'h48, 16'b00000_1_1_01001000_0, 11);
    wait_done("odd", 200);

    // FIFO fill with continuous valid
    sel = 0;
    i = 0; guard = 0; maxc = 0; saw_full = 0;
    @(negedge clk);
    vld = 1'b1;
    while (i < 6 && guard < 2000) begin
      din = 8'h41 + 8'(i);
      r = rdy_m;
      if (int'(cnt_m) > maxc) maxc = int'(cnt_m);
      if (cnt_m == 3'd4 && !rdy_m) saw_full = 1;
      @(posedge clk);
      @(negedge clk);
      guard++;
      if (r) begin
        sb.push_back('{fw[i], 10, (i == 0) ? cyc : -1, i > 0});
        i++;
      end
    end
    vld = 1'b0;
    check("fill_words_accepted", i, 6);
    check("fill_max_count", maxc, 4);
    check("fill_ready_low_when_full", int'(saw_full), 1);
    wait_done("fill", 800);

    // 5 data bits, 2 stop bits, 3 clocks per bit
    sel = 3;
    push_word(8'h15, 16'b00000000_11_10101_0, 8);
    wait_done("fmt", 200);

    // Reset in the middle of a data bit with two words still buffered
    sel = 0;
    mon_en = 0;
    @(negedge clk);
    din = 8'h00;
    vld = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
    repeat (6) @(negedge clk);
    check("count_before_reset", int'(cnt_m), 2);
    check("line_low_in_data", int'(tx_m), 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset_tx", int'(tx_m), 1);
    check("midreset_count", int'(cnt_m), 0);
    check("midreset_busy", int'(busy_m), 0);
    check("midreset_ready", int'(rdy_m), 1);
    rst_n = 1'b1;
    mon_en = 1;
    repeat (100) @(negedge clk);
    check("after_reset_tx", int'(tx_m), 1);
    check("after_reset_count", int'(cnt_m), 0);
    check("after_reset_busy", int'(busy_m), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
